// File: rtl/pipe_pkg.sv
// Shared pipeline-control constants: operand-forwarding selects and the PC register index.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  localparam int PC_REG = 15;

endpackage

// File: rtl/hazard_tagpipe.sv
// E/M/W register-tag pipeline with valid bits; the E stage loads every cycle
// unless flushed, so only the D-stage indices are needed from the datapath.
module hazard_tagpipe #(
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_e_i,
  input  logic [RW-1:0] ra1_d_i,
  input  logic [RW-1:0] ra2_d_i,
  input  logic [RW-1:0] wa3_d_i,
  output logic          v_e_o,
  output logic [RW-1:0] ra1_e_o,
  output logic [RW-1:0] ra2_e_o,
  output logic [RW-1:0] wa3_e_o,
  output logic          v_m_o,
  output logic [RW-1:0] wa3_m_o,
  output logic          v_w_o,
  output logic [RW-1:0] wa3_w_o
);

  logic          v_e_q, v_e_d, v_m_q, v_m_d, v_w_q, v_w_d;
  logic [RW-1:0] ra1_e_q, ra1_e_d, ra2_e_q, ra2_e_d, wa3_e_q, wa3_e_d;
  logic [RW-1:0] wa3_m_q, wa3_m_d, wa3_w_q, wa3_w_d;

  always_comb begin
    v_e_d   = 1'b1;
    ra1_e_d = ra1_d_i;
    ra2_e_d = ra2_d_i;
    wa3_e_d = wa3_d_i;
    if (flush_e_i) begin
      v_e_d   = 1'b0;
      ra1_e_d = '0;
      ra2_e_d = '0;
      wa3_e_d = '0;
    end
    v_m_d   = v_e_q;
    wa3_m_d = wa3_e_q;
    v_w_d   = v_m_q;
    wa3_w_d = wa3_m_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_e_q   <= 1'b0;
      ra1_e_q <= '0;
      ra2_e_q <= '0;
      wa3_e_q <= '0;
      v_m_q   <= 1'b0;
      wa3_m_q <= '0;
      v_w_q   <= 1'b0;
      wa3_w_q <= '0;
    end else begin
      v_e_q   <= v_e_d;
      ra1_e_q <= ra1_e_d;
      ra2_e_q <= ra2_e_d;
      wa3_e_q <= wa3_e_d;
      v_m_q   <= v_m_d;
      wa3_m_q <= wa3_m_d;
      v_w_q   <= v_w_d;
      wa3_w_q <= wa3_w_d;
    end
  end

  assign v_e_o   = v_e_q;
  assign ra1_e_o = ra1_e_q;
  assign ra2_e_o = ra2_e_q;
  assign wa3_e_o = wa3_e_q;
  assign v_m_o   = v_m_q;
  assign wa3_m_o = wa3_m_q;
  assign v_w_o   = v_w_q;
  assign wa3_w_o = wa3_w_q;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forwarding control for the 5-stage core, plus saturating
// stall and flush event counters for performance debug.
module hazard_unit #(
  parameter int RW     = 4,
  parameter int PC_REG = pipe_pkg::PC_REG,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RW-1:0]    RA1D,
  input  logic [RW-1:0]    RA2D,
  input  logic [RW-1:0]    WA3D,
  input  logic             MemtoRegE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCWrPendingF,
  input  logic             PCSrcW,
  input  logic             BranchTakenD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import pipe_pkg::*;

  localparam logic [RW-1:0]    PC_IDX  = RW'(PC_REG);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic          v_e, v_m, v_w;
  logic [RW-1:0] ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
  logic          ldr_stall;
  logic          flush_d, flush_e;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  hazard_tagpipe #(.RW(RW)) u_tagpipe (
    .clk       (clk),
    .reset     (reset),
    .flush_e_i (flush_e),
    .ra1_d_i   (RA1D),
    .ra2_d_i   (RA2D),
    .wa3_d_i   (WA3D),
    .v_e_o     (v_e),
    .ra1_e_o   (ra1_e),
    .ra2_e_o   (ra2_e),
    .wa3_e_o   (wa3_e),
    .v_m_o     (v_m),
    .wa3_m_o   (wa3_m),
    .v_w_o     (v_w),
    .wa3_w_o   (wa3_w)
  );

  // M beats W so the youngest producer wins; the PC is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] src);
    if (v_m && RegWriteM && src == wa3_m && src != PC_IDX)
      return FWD_M;
    else if (v_w && RegWriteW && src == wa3_w && src != PC_IDX)
      return FWD_W;
    else
      return FWD_RF;
  endfunction

  assign ldr_stall = !reset && MemtoRegE && v_e && (wa3_e != PC_IDX) &&
                     ((RA1D == wa3_e) || (RA2D == wa3_e));

  assign flush_d = reset || PCWrPendingF || PCSrcW || BranchTakenD;
  assign flush_e = reset || ldr_stall || BranchTakenD;

  assign StallF    = ldr_stall || (PCWrPendingF && !reset);
  assign StallD    = ldr_stall;
  assign FlushD    = flush_d;
  assign FlushE    = flush_e;
  assign ForwardAE = reset ? FWD_RF : fwd_sel(ra1_e);
  assign ForwardBE = reset ? FWD_RF : fwd_sel(ra2_e);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ldr_stall && stall_cnt_q != CNT_MAX)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (!reset && (flush_d || flush_e) && flush_cnt_q != CNT_MAX)
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
